// File: rtl/alu16_stage.sv
// alu16_stage: registered, handshaked Hack-style ALU stage.
// Operands plus {zx,nx,zy,ny,f,no} are evaluated combinationally on accept and
// captured with their zr/ng flags into a two-entry (main + skid) output buffer.
// The main entry drives out/zr/ng/out_valid; in_ready is a registered !skid_valid.
module alu16_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [5:0]       ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
);

    logic             zx, nx, zy, ny, fn, no;
    logic [WIDTH-1:0] x1, x2, y1, y2, r, o_c;
    logic             zr_c, ng_c;

    logic             accept, pop;
    logic             skid_valid, skid_valid_nx;
    logic [WIDTH-1:0] skid_out;
    logic             skid_zr, skid_ng;

    assign {zx, nx, zy, ny, fn, no} = ctrl;
    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    // ALU datapath: zero/negate preconditioning, add or AND, optional output negation, flags.
    always_comb begin
        x1   = zx ? '0 : x;
        x2   = nx ? ~x1 : x1;
        y1   = zy ? '0 : y;
        y2   = ny ? ~y1 : y1;
        r    = fn ? (x2 + y2) : (x2 & y2);
        o_c  = no ? ~r : r;
        zr_c = (o_c == '0);
        ng_c = o_c[WIDTH-1];
    end

    // Next skid occupancy; in_ready is registered from this so it never sees in_valid/out_ready directly.
    always_comb begin
        skid_valid_nx = skid_valid;
        if (pop && skid_valid)
            skid_valid_nx = 1'b0;
        else if (accept && out_valid && !pop)
            skid_valid_nx = 1'b1;
    end

    // Buffer update: skid refills main on a pop, otherwise new results fill main first, then skid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out        <= '0;
            zr         <= 1'b1;
            ng         <= 1'b0;
            skid_valid <= 1'b0;
            skid_out   <= '0;
            skid_zr    <= 1'b1;
            skid_ng    <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            skid_valid <= skid_valid_nx;
            in_ready   <= !skid_valid_nx;
            if (pop && skid_valid) begin
                // in_ready is 0 whenever skid is full, so no accept can collide with this shift
                out       <= skid_out;
                zr        <= skid_zr;
                ng        <= skid_ng;
                out_valid <= 1'b1;
            end else if (accept && (!out_valid || pop)) begin
                out       <= o_c;
                zr        <= zr_c;
                ng        <= ng_c;
                out_valid <= 1'b1;
            end else if (accept) begin
                skid_out  <= o_c;
                skid_zr   <= zr_c;
                skid_ng   <= ng_c;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu16_stage.sv
// Testbench for alu16_stage: directed vectors with hand-computed results,
// backpressure/recovery, async reset, and a scoreboarded random run.
module tb_alu16_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x, y;
    logic [5:0]  ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        zr, ng;

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic [17:0] q[$];
    logic [17:0] e;

    alu16_stage #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .ctrl      (ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zr        (zr),
        .ng        (ng)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference ALU: returns {zr, ng, out}
    function automatic logic [17:0] ref_alu(input logic [15:0] a, input logic [15:0] b, input logic [5:0] c);
        logic [15:0] aa, bb, rr;
        aa = c[5] ? 16'h0000 : a;
        if (c[4]) aa = ~aa;
        bb = c[3] ? 16'h0000 : b;
        if (c[2]) bb = ~bb;
        rr = c[1] ? 16'(aa + bb) : (aa & bb);
        if (c[0]) rr = ~rr;
        return {(rr == 16'h0000), rr[15], rr};
    endfunction

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic [5:0] c);
        in_valid = v;
        x        = a;
        y        = b;
        ctrl     = c;
    endtask

    task automatic check_out(input string tag, input logic [15:0] o, input logic z, input logic n);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_out"}, out, o);
        check({tag, "_zr"}, zr, z);
        check({tag, "_ng"}, ng, n);
    endtask

    logic [5:0]  sw_ctrl [8] = '{6'b000010, 6'b010011, 6'b000111, 6'b101010,
                                 6'b111010, 6'b111111, 6'b000000, 6'b010101};
    logic [15:0] sw_out  [8] = '{16'h0008, 16'h0002, 16'hFFFE, 16'h0000,
                                 16'hFFFF, 16'h0001, 16'h0001, 16'h0007};
    logic        sw_zr   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        sw_ng   [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        // ---- reset with random inputs ----
        rst_n     = 1'b0;
        out_ready = 1'($urandom);
        drive(1'($urandom), 16'($urandom), 16'($urandom), 6'($urandom));
        repeat (3) @(negedge clk);
        check("rst_ovalid", out_valid, 1'b0);
        check("rst_iready", in_ready, 1'b1);
        check("rst_out", out, 16'h0000);
        check("rst_zr", zr, 1'b1);
        check("rst_ng", ng, 1'b0);
        rst_n     = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 6'h0);
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_ovalid", out_valid, 1'b0);

        // ---- function sweep, back-to-back, latency 1 ----
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'h0005, 16'h0003, sw_ctrl[i]);
            check($sformatf("sweep%0d_iready", i), in_ready, 1'b1);
            @(negedge clk);
            check_out($sformatf("sweep%0d", i), sw_out[i], sw_zr[i], sw_ng[i]);
        end

        // ---- wrap-around ----
        drive(1'b1, 16'hFFFF, 16'h0001, 6'b000010);
        @(negedge clk);
        check_out("wrap0", 16'h0000, 1'b1, 1'b0);
        drive(1'b1, 16'h7FFF, 16'h0001, 6'b000010);
        @(negedge clk);
        check_out("wrap1", 16'h8000, 1'b0, 1'b1);
        drive(1'b0, 16'h0, 16'h0, 6'h0);
        @(negedge clk);
        check("wrap_drain", out_valid, 1'b0);

        // ---- backpressure: 3 ops, only 2 absorbed ----
        out_ready = 1'b0;
        drive(1'b1, 16'h0000, 16'h0000, 6'b000010);
        @(negedge clk);
        check_out("bp_a", 16'h0000, 1'b1, 1'b0);
        check("bp_a_iready", in_ready, 1'b1);
        drive(1'b1, 16'h0001, 16'h0001, 6'b000010);
        @(negedge clk);
        check("bp_b_iready", in_ready, 1'b0);
        check_out("bp_b", 16'h0000, 1'b1, 1'b0);
        drive(1'b1, 16'h0002, 16'h0002, 6'b000010);
        repeat (2) begin
            @(negedge clk);
            check("bp_hold_iready", in_ready, 1'b0);
            check_out("bp_hold", 16'h0000, 1'b1, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_out("bp_r1", 16'h0002, 1'b0, 1'b0);
        check("bp_r1_iready", in_ready, 1'b1);
        @(negedge clk);
        check_out("bp_r2", 16'h0004, 1'b0, 1'b0);
        drive(1'b0, 16'h0, 16'h0, 6'h0);
        @(negedge clk);
        check("bp_drain", out_valid, 1'b0);

        // ---- random stress with scoreboard ----
        q.delete();
        for (int i = 0; i < 10004; i++) begin
            if (i < 10000) begin
                drive(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), 6'($urandom));
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                drive(1'b0, 16'h0, 16'h0, 6'h0);
                out_ready = 1'b1;
            end
            #1;
            check("st_iready", in_ready, (q.size() < 2));
            check("st_ovalid", out_valid, (q.size() != 0));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("st_underflow", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("st_out", out, e[15:0]);
                    check("st_zr", zr, e[17]);
                    check("st_ng", ng, e[16]);
                end
            end
            if (in_valid && in_ready)
                q.push_back(ref_alu(x, y, ctrl));
            @(negedge clk);
        end
        check("st_empty", q.size(), 0);

        // ---- reset mid-stall (async, between edges) ----
        out_ready = 1'b0;
        drive(1'b1, 16'h0003, 16'h0003, 6'b000010);
        @(negedge clk);
        drive(1'b1, 16'h0005, 16'h0005, 6'b000010);
        @(negedge clk);
        drive(1'b0, 16'h0, 16'h0, 6'h0);
        check("ms_full_iready", in_ready, 1'b0);
        check_out("ms_full", 16'h0006, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("ms_rst_ovalid", out_valid, 1'b0);
        check("ms_rst_iready", in_ready, 1'b1);
        check("ms_rst_out", out, 16'h0000);
        check("ms_rst_zr", zr, 1'b1);
        check("ms_rst_ng", ng, 1'b0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        check("ms_rel_ovalid", out_valid, 1'b0);
        drive(1'b1, 16'h0004, 16'h0004, 6'b000010);
        @(negedge clk);
        check_out("ms_new", 16'h0008, 1'b0, 1'b0);
        drive(1'b0, 16'h0, 16'h0, 6'h0);
        @(negedge clk);
        check("ms_no_stale", out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
